// File: rtl/sram_like_resp.sv
// -----------------------------------------------------------------------------
// sram_like_resp
//
// Turns a synchronous single-port RAM (one-cycle read latency) into an
// SRAM-like request/response slave. Requests are accepted on req && addr_ok and
// go straight to the RAM port in the same cycle. One data_ok pulse is returned
// per accepted request, strictly in acceptance order. Write responses carry
// rdata = 0. At most two requests are outstanding at any time.
//
// Optional feature (macro SRAM_RESP_DELAY_EN): a 16-bit Fibonacci LFSR
// (taps 16,14,13,11) adds a pseudo-random extra delay of 0..7 cycles to each
// response. Without the macro every response comes exactly one cycle after
// acceptance.
//
// Ports
//   clk        in   clock, all logic on the rising edge
//   reset      in   synchronous active-high reset
//   req        in   master request valid
//   wen[3:0]   in   byte write enables, 4'h0 means read
//   addr[31:0] in   byte address (bits [1:0] ignored)
//   wdata[31:0]in   write data
//   addr_ok    out  request accepted this cycle when req is also high
//   data_ok    out  one-cycle response pulse
//   rdata[31:0]out  response data, zero whenever data_ok is low
//   ram_en     out  RAM port enable
//   ram_wen[3:0]out RAM byte write enables
//   ram_addr   out  RAM word address, addr[RAM_AW+1:2]
//   ram_wdata  out  RAM write data
//   ram_rdata  in   RAM read data, valid the cycle after a read enable
// -----------------------------------------------------------------------------
module sram_like_resp #(
    parameter int          RAM_AW    = 16,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic [3:0]        wen,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    output logic              addr_ok,
    output logic              data_ok,
    output logic [31:0]       rdata,
    output logic              ram_en,
    output logic [3:0]        ram_wen,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata
);

    // Outstanding request count (accepted, not yet answered): 0..2
    logic [1:0]  out_q, out_d;

    // Entry whose RAM access was issued last cycle; its read data is on
    // ram_rdata in the current cycle.
    logic        p_vld_q, p_vld_d;
    logic        p_wr_q,  p_wr_d;
    logic [2:0]  p_dly_q, p_dly_d;

    // Two-entry in-order response FIFO. Write responses are stored with data
    // already forced to zero, so the is_write flag is folded into the data.
    logic [1:0]  f_vld_q, f_vld_d;
    logic [2:0]  f_dly_q [2];
    logic [2:0]  f_dly_d [2];
    logic [31:0] f_data_q [2];
    logic        wp_q, wp_d;
    logic        rp_q, rp_d;

    logic        accept;
    logic        fifo_empty;
    logic        head_rdy;
    logic        bypass;
    logic        push;
    logic [31:0] arr_data;
    logic [2:0]  new_dly;

`ifdef SRAM_RESP_DELAY_EN
    logic [15:0] lfsr_q, lfsr_d;
    logic        unused_bits;

    // The delay for a request is taken from the LFSR value current at its
    // acceptance; the LFSR then advances.
    assign new_dly = lfsr_q[2:0];
    assign lfsr_d  = accept ? {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]}
                            : lfsr_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign unused_bits = ^addr;
`else
    logic        unused_bits;

    assign new_dly     = 3'd0;
    assign unused_bits = ^{addr, LFSR_SEED};
`endif

    // Handshake and RAM port; nothing is issued while reset is held.
    assign accept    = req && addr_ok && !reset;
    assign ram_en    = accept;
    assign ram_wen   = accept ? wen : 4'h0;
    assign ram_addr  = addr[RAM_AW+1:2];
    assign ram_wdata = wdata;

    // Response selection: FIFO head when its delay has expired, otherwise the
    // arriving entry directly when the FIFO is empty and it has no delay.
    assign arr_data   = p_wr_q ? 32'h0 : ram_rdata;
    assign fifo_empty = !f_vld_q[rp_q];
    assign head_rdy   = f_vld_q[rp_q] && (f_dly_q[rp_q] == 3'd0);
    assign bypass     = fifo_empty && p_vld_q && (p_dly_q == 3'd0);
    assign push       = p_vld_q && !bypass;

    assign data_ok = (head_rdy || bypass) && !reset;
    assign rdata   = !data_ok ? 32'h0 : (bypass ? arr_data : f_data_q[rp_q]);
    assign addr_ok = (out_q < 2'd2) || data_ok;

    always_comb begin
        out_d = out_q;
        case ({accept, data_ok})
            2'b10:   out_d = out_q + 2'd1;
            2'b01:   out_d = out_q - 2'd1;
            default: out_d = out_q;
        endcase

        p_vld_d = accept;
        p_wr_d  = (wen != 4'h0);
        p_dly_d = new_dly;

        f_vld_d = f_vld_q;
        f_dly_d = f_dly_q;
        wp_d    = wp_q;
        rp_d    = rp_q;

        // Only the head entry counts down.
        if (f_vld_q[rp_q] && (f_dly_q[rp_q] != 3'd0)) begin
            f_dly_d[rp_q] = f_dly_q[rp_q] - 3'd1;
        end

        if (head_rdy) begin
            f_vld_d[rp_q] = 1'b0;
            rp_d          = ~rp_q;
        end

        // An entry entering an empty FIFO is already the head in its arrival
        // cycle, so that cycle counts toward its delay (p_dly_q is nonzero
        // here, otherwise it would have bypassed). Behind another entry it
        // starts counting only once it reaches the head.
        if (push) begin
            f_vld_d[wp_q] = 1'b1;
            f_dly_d[wp_q] = fifo_empty ? (p_dly_q - 3'd1) : p_dly_q;
            wp_d          = ~wp_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_q   <= 2'd0;
            p_vld_q <= 1'b0;
            p_wr_q  <= 1'b0;
            p_dly_q <= 3'd0;
            f_vld_q <= 2'b00;
            f_dly_q <= '{3'd0, 3'd0};
            wp_q    <= 1'b0;
            rp_q    <= 1'b0;
        end else begin
            out_q   <= out_d;
            p_vld_q <= p_vld_d;
            p_wr_q  <= p_wr_d;
            p_dly_q <= p_dly_d;
            f_vld_q <= f_vld_d;
            f_dly_q <= f_dly_d;
            wp_q    <= wp_d;
            rp_q    <= rp_d;
        end
    end

    // FIFO payload carries no reset; it is qualified by the valid bits.
    always_ff @(posedge clk) begin
        if (push) begin
            f_data_q[wp_q] <= arr_data;
        end
    end

endmodule

// File: tb/tb_sram_like_resp.sv
// -----------------------------------------------------------------------------
// tb_sram_like_resp
//
// Drives sram_like_resp against a behavioural RAM. A reference model tracks the
// accepted requests as a queue of (expected data, due cycle). A response is due
// at max(acceptance+1, previous due+1) + extra delay, where the extra delay is
// the reference LFSR's low three bits when SRAM_RESP_DELAY_EN is defined and
// zero otherwise. Expected read data comes from a shadow copy of the memory.
// -----------------------------------------------------------------------------
module tb_sram_like_resp;
    localparam int          RAM_AW = 16;
    localparam logic [15:0] SEED   = 16'hACE1;

    logic              clk = 1'b0;
    logic              reset;
    logic              req;
    logic [3:0]        wen;
    logic [31:0]       addr;
    logic [31:0]       wdata;
    logic              addr_ok;
    logic              data_ok;
    logic [31:0]       rdata;
    logic              ram_en;
    logic [3:0]        ram_wen;
    logic [RAM_AW-1:0] ram_addr;
    logic [31:0]       ram_wdata;
    logic [31:0]       ram_rdata;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;

    typedef struct {
        logic [31:0] data;
        int          due;
    } resp_t;

    resp_t       exp_q [$];
    int          last_due = -10;
    logic [15:0] lfsr_m   = SEED;
    logic [31:0] ref_mem [256];
    logic        preload  = 1'b1;

    always #5 clk = ~clk;

    sram_like_resp #(.RAM_AW(RAM_AW), .LFSR_SEED(SEED)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .wen       (wen),
        .addr      (addr),
        .wdata     (wdata),
        .addr_ok   (addr_ok),
        .data_ok   (data_ok),
        .rdata     (rdata),
        .ram_en    (ram_en),
        .ram_wen   (ram_wen),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
    );

    function automatic logic [31:0] init_word(input int i);
        if (i < 3) return 32'(i + 1) * 32'h11;
        return {8'hA5, 8'(i), 8'(~i), 8'(i * 7)};
    endfunction

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    // Behavioural RAM: one-cycle read latency, garbage on idle cycles.
    logic [31:0] mem [256];
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
            ram_rdata <= 32'h0;
        end else if (ram_en) begin
            for (int b = 0; b < 4; b++)
                if (ram_wen[b]) mem[ram_addr[7:0]][b*8 +: 8] <= ram_wdata[b*8 +: 8];
            ram_rdata <= mem[ram_addr[7:0]];
        end else begin
            ram_rdata <= $urandom;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, expv, cyc);
        end
    endtask

    // One clock cycle: drive inputs just after the falling edge, check all
    // outputs 1 ns later, update the model, then wait for the next falling edge.
    task automatic step(input logic rs, input logic r, input logic [3:0] w,
                        input logic [31:0] a, input logic [31:0] d);
        logic        e_dok, e_ok, e_acc;
        logic [31:0] e_rd;
        int          dly, start;
        resp_t       ent;
        reset = rs; req = r; wen = w; addr = a; wdata = d;
        #1;
        e_dok = !rs && (exp_q.size() > 0) && (exp_q[0].due == cyc);
        e_rd  = e_dok ? exp_q[0].data : 32'h0;
        e_ok  = (exp_q.size() < 2) || e_dok;
        e_acc = !rs && r && e_ok;
        chk("data_ok", {31'b0, data_ok}, {31'b0, e_dok});
        chk("rdata", rdata, e_rd);
        if (!rs) chk("addr_ok", {31'b0, addr_ok}, {31'b0, e_ok});
        chk("ram_en", {31'b0, ram_en}, {31'b0, e_acc});
        chk("ram_wen", {28'b0, ram_wen}, {28'b0, (e_acc ? w : 4'h0)});
        if (e_acc) begin
            chk("ram_addr", {16'b0, ram_addr}, {16'b0, a[RAM_AW+1:2]});
            chk("ram_wdata", ram_wdata, d);
        end
        if (e_dok) void'(exp_q.pop_front());
        if (rs) begin
            exp_q.delete();
            last_due = -10;
            lfsr_m   = SEED;
        end else if (e_acc) begin
`ifdef SRAM_RESP_DELAY_EN
            dly = int'(lfsr_m[2:0]);
`else
            dly = 0;
`endif
            lfsr_m   = lfsr_next(lfsr_m);
            start    = (cyc + 1 > last_due + 1) ? cyc + 1 : last_due + 1;
            ent.due  = start + dly;
            last_due = ent.due;
            ent.data = (w == 4'h0) ? ref_mem[a[9:2]] : 32'h0;
            for (int b = 0; b < 4; b++)
                if (w[b]) ref_mem[a[9:2]][b*8 +: 8] = d[b*8 +: 8];
            exp_q.push_back(ent);
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 4'h0, $urandom, $urandom);
    endtask

    initial begin
        logic        rs, r;
        logic [3:0]  w;
        bit          did_rst;
        for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
        reset = 1'b1; req = 1'b0; wen = 4'h0; addr = 32'h0; wdata = 32'h0;
        @(negedge clk);
        step(1'b1, 1'b0, 4'h0, 32'h0, 32'h0);
        preload = 1'b0;
        // Request held high during reset must not reach the RAM.
        step(1'b1, 1'b1, 4'hF, 32'h40, 32'h1234);

        // Three consecutive reads of preloaded words 0x11, 0x22, 0x33.
        step(1'b0, 1'b1, 4'h0, 32'h0, 32'h0);
        step(1'b0, 1'b1, 4'h0, 32'h4, 32'h0);
        step(1'b0, 1'b1, 4'h0, 32'h8, 32'h0);
        idle(10);

        // Full-word write then read-back at byte address 0x10 (word 4).
        step(1'b0, 1'b1, 4'hF, 32'h10, 32'hDEADBEEF);
        step(1'b0, 1'b1, 4'h0, 32'h10, 32'h0);
        idle(10);

        // Partial byte writes, ignored low address bits, high address bits.
        step(1'b0, 1'b1, 4'b0101, 32'h13, 32'h11223344);
        step(1'b0, 1'b1, 4'b1000, 32'hFFFC_0011, 32'hAABBCCDD);
        step(1'b0, 1'b1, 4'h0, 32'h12, 32'h0);
        idle(10);

        // Request held high continuously; reset once two are outstanding.
        did_rst = 1'b0;
        for (int i = 0; i < 60; i++) begin
            rs = !did_rst && (exp_q.size() == 2);
            if (rs) did_rst = 1'b1;
            step(rs, 1'b1, 4'h0, $urandom, $urandom);
        end
        // Reset with a request in flight regardless of the delay setting.
        step(1'b1, 1'b1, 4'h0, 32'h20, 32'h0);
        idle(12);

        // Randomised traffic with occasional resets and idle gaps.
        for (int i = 0; i < 600; i++) begin
            rs = ($urandom_range(0, 99) == 0);
            r  = ($urandom_range(0, 3) != 0);
            w  = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
            step(rs, r, w, $urandom, $urandom);
        end

        // Drain every in-flight response.
        idle(30);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/sram_like_resp.md
SRAM_LIKE_RESP -- requirements
Module: sram_like_resp

Interface
REQ-001 Parameter RAM_AW, default 16: backing-RAM word-address width.
REQ-002 Parameter LFSR_SEED, default 16'hACE1: delay-LFSR reset value (used only with SRAM_RESP_DELAY_EN).
REQ-003 clk  input  1  single clock; all logic on posedge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req  input  1  master request valid.
REQ-006 wen  input  4  byte write enables; 4'h0 = read.
REQ-007 addr  input  32  byte address; addr[1:0] ignored.
REQ-008 wdata  input  32  write data.
REQ-009 addr_ok  output  1  request accepted this cycle when req && addr_ok.
REQ-010 data_ok  output  1  one-cycle response pulse, no master backpressure.
REQ-011 rdata  output  32  read data, valid only while data_ok.
REQ-012 ram_en  output  1  backing-RAM port enable.
REQ-013 ram_wen  output  4  backing-RAM byte write enables.
REQ-014 ram_addr  output  RAM_AW  word address = addr[RAM_AW+1:2].
REQ-015 ram_wdata  output  32  = wdata.
REQ-016 ram_rdata  input  32  RAM read data, valid the cycle after ram_en with ram_wen == 0.

Function
REQ-017 Handshake: a request is accepted in any cycle with req && addr_ok; RAM access is issued that same cycle (ram_en = req && addr_ok, ram_wen = wen when accepted, else 4'h0).
REQ-018 Outstanding counter (0..2): +1 on acceptance, -1 on data_ok, unchanged when both occur in the same cycle.
REQ-019 addr_ok = (outstanding < 2) || data_ok; it depends on no other input.
REQ-020 Responses are returned strictly in acceptance order, exactly one data_ok per accepted request.
REQ-021 Writes also return data_ok; rdata = 32'h0 for a write response.
REQ-022 Read data is captured from ram_rdata the cycle after acceptance into a 2-entry in-order response FIFO (entry = is_write + data).
REQ-023 FIFO pointers wrap modulo 2; simultaneous push and pop leave occupancy unchanged; push never occurs when full (guaranteed by REQ-019).
REQ-024 data_ok asserts when the FIFO head is valid and its delay counter is 0 (see Configuration), or when bypass applies (REQ-025).
REQ-025 Bypass: when the FIFO is empty and the entry arriving this cycle has delay 0, data_ok and rdata come directly from ram_rdata; minimum latency is 1 cycle after acceptance.
REQ-026 Back-to-back: with zero delay, one acceptance and one data_ok per cycle is sustained indefinitely.

Reset
REQ-027 Reset clears outstanding, FIFO valid bits, pointers and delay counters, and loads the LFSR with LFSR_SEED.
REQ-028 During and after reset: data_ok = 0, ram_en = 0, ram_wen = 0, rdata = 0, addr_ok = 1 (first cycle after reset).
REQ-029 Reset mid-operation drops all in-flight requests; no data_ok is ever produced for them.

Configuration
REQ-030 Macro SRAM_RESP_DELAY_EN: when defined, a 16-bit Fibonacci LFSR (taps 16,14,13,11) advances every accepted request, and LFSR[2:0] is loaded as the entry's extra delay (0..7 cycles). The counter counts down only while that entry is at the FIFO head.
REQ-031 Without SRAM_RESP_DELAY_EN: no LFSR is present, every delay is 0, and data_ok follows each acceptance by exactly 1 cycle.

Verification
REQ-032 Macro off, reads of 0x0,0x4,0x8 on consecutive cycles, RAM words 0x11,0x22,0x33 -> data_ok on cycles 1,2,3 with rdata 0x11,0x22,0x33.
REQ-033 Write wen=4'hF addr=0x10 wdata=0xDEADBEEF, then read 0x10 -> write data_ok with rdata 0, then read data_ok with rdata 0xDEADBEEF; ram_addr = 0x4.
REQ-034 Macro on, seed 16'hACE1, req held high continuously -> addr_ok drops whenever outstanding = 2 with no data_ok; responses stay in order; delays match a reference LFSR model.
REQ-035 Macro on, reset asserted with 2 requests outstanding -> no data_ok after reset; addr_ok = 1 the cycle after reset deasserts.
REQ-036 Macro on, simultaneous acceptance and data_ok at outstanding = 2 -> outstanding stays 2, no response lost or duplicated.
